por_seq_ctrl: RTL and testbench

Parametrised power-on-reset sequencer, successor to the single-channel POR/reset generator in the pad-ring reset path. Synchronises the de-asserting edge of the external reset, then releases NUM_CH downstream reset domains one at a time, STEP_CYCLES apart. Adds a software-requested warm reset that re-runs the release sequence without dropping the POR outputs. Sits between the reset pad and all core reset domains.

---
 rtl/por_seq_pkg.sv | 24 ++
 rtl/por_sync_chain.sv | 24 ++
 rtl/por_seq_ctrl.sv | 112 +++++++++++
 tb/tb_por_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/por_seq_pkg.sv
// Shared types and helpers for the power-on-reset sequencer.
// State encodings double as the debug state_o values.
package por_seq_pkg;

  localparam logic [1:0] ENC_HOLD    = 2'd0;
  localparam logic [1:0] ENC_RELEASE = 2'd1;
  localparam logic [1:0] ENC_RUN     = 2'd2;
  localparam logic [1:0] ENC_SWRST   = 2'd3;

  typedef enum logic [1:0] {
    ST_HOLD    = ENC_HOLD,
    ST_RELEASE = ENC_RELEASE,
    ST_RUN     = ENC_RUN,
    ST_SWRST   = ENC_SWRST
  } por_state_e;

  // Counter width for the larger of two cycle counts, never below 1 bit.
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/por_sync_chain.sv
// Async-clear shift register that synchronises the release edge of a pad reset.
// Output rises on the STAGES-th clock edge after resetb_in de-asserts.
module por_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetb_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge resetb_in) begin
    if (!resetb_in) chain <= '0;
    else            chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign sync_out = chain[STAGES-1];

  if (STAGES < 2) begin : g_bad_stages
    $error("por_sync_chain: STAGES must be 2 or more");
  end

endmodule

// File: rtl/por_seq_ctrl.sv
// Power-on-reset sequencer: synchronised POR plus staggered release of NUM_CH
// reset domains. Warm reset via sw_rst_req exists only when POR_SWRST_EN is defined.
module por_seq_ctrl
  import por_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int NUM_CH       = 3,
  parameter int STEP_CYCLES  = 4,
  parameter int SWRST_CYCLES = 8
) (
  input  logic              clk,
  input  logic              resetb_in,
  input  logic              sw_rst_req,
  output logic              porb_h,
  output logic              porb_l,
  output logic              por_l,
  output logic [NUM_CH-1:0] rstb_h,
  output logic              ready,
  output logic [1:0]        state_o
);

  localparam int CW = clog2_max(STEP_CYCLES, SWRST_CYCLES);
  localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] SWRST_LAST = CW'(SWRST_CYCLES - 1);

  por_state_e        state;
  logic [CW-1:0]     cnt;
  logic              sync_porb;
  logic              sw_take;
  logic [NUM_CH-1:0] rstb_next;

  por_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .resetb_in (resetb_in),
    .sync_out  (sync_porb)
  );

  assign porb_h  = sync_porb;
  assign porb_l  = sync_porb;
  assign por_l   = ~sync_porb;
  assign state_o = state;

  // Channels release lowest bit first, so the next pattern is a shift-in of 1.
  assign rstb_next = (rstb_h << 1) | NUM_CH'(1);

`ifdef POR_SWRST_EN
  assign sw_take = sw_rst_req;
`else
  logic sw_rst_unused;
  assign sw_rst_unused = sw_rst_req;
  assign sw_take       = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetb_in) begin
    if (!resetb_in) begin
      state  <= ST_HOLD;
      cnt    <= '0;
      rstb_h <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        // The HOLD exit edge is the first step, so channel k releases
        // (k+1)*STEP_CYCLES edges after porb_h rises.
        ST_HOLD, ST_RELEASE: begin
          if (state == ST_RELEASE || sync_porb) begin
            state <= ST_RELEASE;
            if (cnt == STEP_LAST) begin
              cnt    <= '0;
              rstb_h <= rstb_next;
              if (rstb_next[NUM_CH-1]) begin
                state <= ST_RUN;
                ready <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_RUN: begin
          if (sw_take) begin
            state  <= ST_SWRST;
            cnt    <= '0;
            rstb_h <= '0;
            ready  <= 1'b0;
          end
        end
        ST_SWRST: begin
          if (cnt == SWRST_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("por_seq_ctrl: SYNC_STAGES must be 2 or more");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("por_seq_ctrl: NUM_CH must be 1 or more");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("por_seq_ctrl: STEP_CYCLES must be 1 or more");
  end
  if (SWRST_CYCLES < 1) begin : g_bad_swrst
    $error("por_seq_ctrl: SWRST_CYCLES must be 1 or more");
  end

endmodule

// File: tb/tb_por_seq_ctrl.sv
// Bench for por_seq_ctrl: default instance checked against an edge-count model,
// plus a NUM_CH=1/STEP_CYCLES=1/SYNC_STAGES=3 instance. Adapts to POR_SWRST_EN.
module tb_por_seq_ctrl;

  localparam int SYNC = 2;
  localparam int NUM  = 3;
  localparam int STEP = 4;
  localparam int SWC  = 8;
`ifdef POR_SWRST_EN
  localparam bit SWRST_ON = 1'b1;
`else
  localparam bit SWRST_ON = 1'b0;
`endif
  localparam logic [8:0] RST_VEC = 9'b001_000_0_00;

  logic           clk;
  logic           resetb;
  logic           sw_rst_req;
  logic           porb_h, porb_l, por_l, ready;
  logic [NUM-1:0] rstb_h;
  logic [1:0]     state_o;
  logic [8:0]     act_vec;

  logic       resetb_p, sw_p;
  logic       p_porb_h, p_porb_l, p_por_l, p_ready;
  logic [0:0] p_rstb;
  logic [1:0] p_state;
  logic [6:0] p_vec;

  int n_checks = 0;
  int n_bad    = 0;

  // Model: edges since reset release, and the edge a warm reset was taken (-1 if none).
  int m_n   = 0;
  int m_swe = -1;

  por_seq_ctrl #(
    .SYNC_STAGES(SYNC), .NUM_CH(NUM), .STEP_CYCLES(STEP), .SWRST_CYCLES(SWC)
  ) dut (
    .clk(clk), .resetb_in(resetb), .sw_rst_req(sw_rst_req),
    .porb_h(porb_h), .porb_l(porb_l), .por_l(por_l),
    .rstb_h(rstb_h), .ready(ready), .state_o(state_o)
  );

  por_seq_ctrl #(
    .SYNC_STAGES(3), .NUM_CH(1), .STEP_CYCLES(1), .SWRST_CYCLES(2)
  ) dut_p (
    .clk(clk), .resetb_in(resetb_p), .sw_rst_req(sw_p),
    .porb_h(p_porb_h), .porb_l(p_porb_l), .por_l(p_por_l),
    .rstb_h(p_rstb), .ready(p_ready), .state_o(p_state)
  );

  assign act_vec = {porb_h, porb_l, por_l, rstb_h, ready, state_o};
  assign p_vec   = {p_porb_h, p_porb_l, p_por_l, p_rstb, p_ready, p_state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_base();
    return (m_swe < 0) ? SYNC : m_swe + SWC;
  endfunction

  function automatic logic [1:0] m_state();
    if (m_swe >= 0 && m_n < m_swe + SWC) return 2'd3;
    if (m_swe < 0 && m_n <= SYNC) return 2'd0;
    if (m_n < m_base() + NUM * STEP) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [8:0] exp_vec();
    logic p;
    logic [NUM-1:0] r;
    p = (m_n >= SYNC);
    for (int k = 0; k < NUM; k++) r[k] = (m_n >= m_base() + (k + 1) * STEP);
    return {p, p, ~p, r, (m_n >= m_base() + NUM * STEP), m_state()};
  endfunction

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_n   = 0;
      m_swe = -1;
    end else begin
      if (SWRST_ON && m_state() == 2'd2 && sw_rst_req) m_swe = m_n + 1;
      m_n = m_n + 1;
    end
  end

  task automatic do_reset();
    resetb     = 1'b0;
    sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
  endtask

  task automatic test_reset();
    resetb = 1'b0; sw_rst_req = 1'b0;
    resetb_p = 1'b0; sw_p = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== RST_VEC) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, act_vec, RST_VEC);
      end
    end
    resetb = 1'b1;
  endtask

  task automatic test_release();
    logic [2:0] spot;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL release n=%0d got=%b exp=%b", m_n, act_vec, exp_vec());
      end
      if (m_n == 2) begin
        n_checks++;
        if (porb_h !== 1'b1 || porb_l !== 1'b1 || por_l !== 1'b0) begin
          n_bad++;
          $display("FAIL por_edge2 got=%b%b%b exp=110", porb_h, porb_l, por_l);
        end
      end
      if (m_n == 6 || m_n == 10 || m_n == 14) begin
        spot = (m_n == 6) ? 3'b001 : (m_n == 10) ? 3'b011 : 3'b111;
        n_checks++;
        if (rstb_h !== spot || ready !== (m_n == 14)) begin
          n_bad++;
          $display("FAIL release_step n=%0d got=%b/%b exp=%b/%b", m_n, rstb_h, ready, spot, (m_n == 14));
        end
      end
    end
    n_checks++;
    if (state_o !== 2'd2) begin
      n_bad++;
      $display("FAIL run_state got=%0d exp=2", state_o);
    end
  endtask

  task automatic test_swrst();
    logic [2:0] spot;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL swrst n=%0d got=%b exp=%b", m_n, act_vec, exp_vec());
      end
      if (m_n == 20) begin
        spot = SWRST_ON ? 3'b000 : 3'b111;
        n_checks++;
        if (rstb_h !== spot || ready !== !SWRST_ON || porb_h !== 1'b1) begin
          n_bad++;
          $display("FAIL swrst_enter got=%b/%b/%b exp=%b/%b/1", rstb_h, ready, porb_h, spot, !SWRST_ON);
        end
      end
      if (m_n == 32 || m_n == 36 || m_n == 40) begin
        spot = !SWRST_ON ? 3'b111 : (m_n == 32) ? 3'b001 : (m_n == 36) ? 3'b011 : 3'b111;
        n_checks++;
        if (rstb_h !== spot) begin
          n_bad++;
          $display("FAIL swrst_release n=%0d got=%b exp=%b", m_n, rstb_h, spot);
        end
      end
      sw_rst_req = (m_n == 19);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL async_pre n=%0d got=%b exp=%b", m_n, act_vec, exp_vec());
      end
    end
    resetb = 1'b0;
    #1;
    n_checks++;
    if (act_vec !== RST_VEC) begin
      n_bad++;
      $display("FAIL async_assert got=%b exp=%b", act_vec, RST_VEC);
    end
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL async_rerun n=%0d got=%b exp=%b", m_n, act_vec, exp_vec());
      end
    end
    n_checks++;
    if (ready !== 1'b1 || rstb_h !== 3'b111) begin
      n_bad++;
      $display("FAIL async_ready got=%b/%b exp=1/111", ready, rstb_h);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    #1 resetb = 1'b0;
    #1;
    n_checks++;
    if (act_vec !== RST_VEC) begin
      n_bad++;
      $display("FAIL glitch_drop got=%b exp=%b", act_vec, RST_VEC);
    end
    #1 resetb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL glitch_rerun n=%0d got=%b exp=%b", m_n, act_vec, exp_vec());
      end
      if (m_n == 1 || m_n == 2 || m_n == 13 || m_n == 14) begin
        n_checks++;
        if (porb_h !== (m_n >= 2) || ready !== (m_n >= 14)) begin
          n_bad++;
          $display("FAIL glitch_edges n=%0d got=%b/%b exp=%b/%b", m_n, porb_h, ready, (m_n >= 2), (m_n >= 14));
        end
      end
    end
  endtask

  task automatic test_swrst_in_release();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL swreq_release n=%0d got=%b exp=%b", m_n, act_vec, exp_vec());
      end
      if (m_n == 14) begin
        n_checks++;
        if (ready !== 1'b1 || state_o !== 2'd2) begin
          n_bad++;
          $display("FAIL swreq_ready got=%b/%0d exp=1/2", ready, state_o);
        end
      end
      if (m_n == 15) begin
        n_checks++;
        if (state_o !== (SWRST_ON ? 2'd3 : 2'd2)) begin
          n_bad++;
          $display("FAIL swreq_follow got=%0d exp=%0d", state_o, (SWRST_ON ? 3 : 2));
        end
      end
      sw_rst_req = (m_n >= 2 && m_n <= 14);
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_param_sweep();
    logic p, r;
    resetb_p = 1'b0;
    sw_p     = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (p_vec !== 7'b001_0_0_00) begin
      n_bad++;
      $display("FAIL sweep_reset got=%b exp=0010000", p_vec);
    end
    resetb_p = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      p = (n >= 3);
      r = (n >= 4);
      n_checks++;
      if (p_vec !== {p, p, ~p, r, r, (n <= 3) ? 2'd0 : 2'd2}) begin
        n_bad++;
        $display("FAIL sweep n=%0d got=%b exp=%b", n, p_vec, {p, p, ~p, r, r, (n <= 3) ? 2'd0 : 2'd2});
      end
    end
  endtask

  task automatic test_random();
    int low_left;
    low_left = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL random i=%0d n=%0d got=%b exp=%b", i, m_n, act_vec, exp_vec());
      end
      if (resetb && $urandom_range(0, 79) == 0) begin
        resetb   = 1'b0;
        low_left = $urandom_range(1, 3);
      end else if (!resetb) begin
        low_left--;
        if (low_left <= 0) resetb = 1'b1;
      end
      sw_rst_req = ($urandom_range(0, 7) == 0);
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_release();
    test_swrst();
    test_async_reset();
    test_glitch();
    test_swrst_in_release();
    test_param_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
